// File: rtl/climate_pkg.sv
// climate_pkg: shared FSM states, ASCII command codes and LCD text for climate_ctrl
package climate_pkg;
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_UPDATE, S_SHOW} state_t;
  localparam logic [7:0] ASCII_0 = 8'h30;
  localparam logic [7:0] CMD_MAX_T = "A";
  localparam logic [7:0] CMD_MIN_T = "B";
  localparam logic [7:0] CMD_MAX_H = "C";
  localparam logic [7:0] CMD_MIN_H = "D";
  localparam logic [7:0] CMD_LOAD = "L";
  localparam logic [7:0] CMD_MODE = "M";
  localparam logic [127:0] LCD_TITLE = "  Cold Storage  ";
  localparam logic [127:0] LCD_WELCOME = "     Welcome    ";
  localparam logic [127:0] LCD_FAULT = "Sensor fault    ";
  function automatic logic is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction
endpackage

// File: rtl/climate_bcd2.sv
// climate_bcd2: value -> two ASCII decimal digits, saturating at "99"
//   val   in  DATA_W  unsigned value
//   ascii out 16      {tens, ones} ASCII
module climate_bcd2 #(
  parameter int DATA_W = 8
) (
  input  logic [DATA_W-1:0] val,
  output logic [15:0]       ascii
);
  import climate_pkg::*;
  logic [6:0] sat;
  assign sat = int'(val) > 99 ? 7'd99 : 7'(val);
  assign ascii = {ASCII_0 + 8'(sat / 7'd10), ASCII_0 + 8'(sat % 7'd10)};
endmodule

// File: rtl/climate_ctrl.sv
// climate_ctrl: periodic sensor polling, hysteresis fan/humidifier control,
// UART threshold/mode commands and two-row LCD text formatting.
//   clk, rst_n                    clock, async active-low reset
//   temperature, humidity         sensor sample, valid with sens_ready
//   sens_req / sens_ready         sample handshake (req held until ready or timeout)
//   cmd_valid, cmd_byte, cmd_val0/1  command strobe, ASCII opcode and two digits
//   cmd_ack / cmd_err             one-cycle command result
//   fan_on, hum_on, alarm, sens_fault  actuators and status
//   lcd_en, lcd_row1, lcd_row2    row update strobe and 16-char rows (MSB leftmost)
module climate_ctrl #(
  parameter int DATA_W         = 8,
  parameter int REFRESH_CYCLES = 100_000_000,
  parameter int TIMEOUT_CYCLES = 50_000_000,
  parameter int HYST           = 2,
  parameter int MAX_TEMP_RST   = 18,
  parameter int MIN_TEMP_RST   = 0,
  parameter int MAX_HUM_RST    = 35,
  parameter int MIN_HUM_RST    = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] temperature,
  input  logic [DATA_W-1:0] humidity,
  output logic              sens_req,
  input  logic              sens_ready,
  input  logic              cmd_valid,
  input  logic [7:0]        cmd_byte,
  input  logic [7:0]        cmd_val0,
  input  logic [7:0]        cmd_val1,
  output logic              cmd_ack,
  output logic              cmd_err,
  output logic              fan_on,
  output logic              hum_on,
  output logic              alarm,
  output logic              sens_fault,
  output logic              lcd_en,
  output logic [127:0]      lcd_row1,
  output logic [127:0]      lcd_row2
);
  import climate_pkg::*;
  state_t state, state_nx;
  logic [31:0] cnt;
  logic idle_done, timeout, manual, digits, cmd_ok, fan_nx, hum_nx;
  logic [DATA_W-1:0] t_lat, h_lat, max_temp, min_temp, max_hum, min_hum;
  logic [DATA_W-1:0] cmd_num, fan_off, hum_off;
  logic [DATA_W:0] hum_sum;
  logic [7:0] num, mode_ch, fan_ch, hum_ch, alm_ch;
  logic [15:0] t_asc, h_asc;

  climate_bcd2 #(.DATA_W(DATA_W)) u_bcd_t (.val(t_lat), .ascii(t_asc));
  climate_bcd2 #(.DATA_W(DATA_W)) u_bcd_h (.val(h_lat), .ascii(h_asc));

  // cnt counts cycles spent in the current state; it restarts on every transition
  assign idle_done = cnt == 32'(REFRESH_CYCLES - 1);
  assign timeout = cnt == 32'(TIMEOUT_CYCLES - 1);

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = idle_done ? S_REQ : S_IDLE;
      S_REQ:    state_nx = S_WAIT;
      S_WAIT:   state_nx = sens_ready ? S_UPDATE : timeout ? S_SHOW : S_WAIT;
      S_UPDATE: state_nx = S_SHOW;
      default:  state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= '0;
      sens_req <= 1'b0;
    end else begin
      state <= state_nx;
      cnt <= state_nx == state ? cnt + 32'd1 : '0;
      sens_req <= state_nx == S_WAIT;
    end

  assign num = 8'd10 * (cmd_val0 - ASCII_0) + (cmd_val1 - ASCII_0);
  assign cmd_num = DATA_W'(num);
  assign digits = is_digit(cmd_val0) && is_digit(cmd_val1);
  assign cmd_ok = cmd_byte == CMD_MAX_T ? digits && cmd_num >= min_temp :
                  cmd_byte == CMD_MIN_T ? digits && cmd_num <= max_temp :
                  cmd_byte == CMD_MAX_H ? digits && cmd_num >= min_hum :
                  cmd_byte == CMD_MIN_H ? digits && cmd_num <= max_hum :
                  cmd_byte == CMD_LOAD  ? digits :
                  cmd_byte == CMD_MODE  ? cmd_val0 == ASCII_0 || cmd_val0 == "1" : 1'b0;

  // release thresholds saturate at the ends of the value range
  assign fan_off = max_temp > DATA_W'(HYST) ? max_temp - DATA_W'(HYST) : '0;
  assign hum_sum = {1'b0, min_hum} + (DATA_W + 1)'(HYST);
  assign hum_off = hum_sum[DATA_W] ? '1 : hum_sum[DATA_W-1:0];
  assign fan_nx = t_lat > max_temp || (t_lat > fan_off && fan_on);
  assign hum_nx = h_lat < min_hum || (h_lat < hum_off && hum_on);

  assign mode_ch = manual ? "M" : "A";
  assign fan_ch = fan_on ? "F" : "-";
  assign hum_ch = hum_on ? "H" : "-";
  assign alm_ch = alarm ? "!" : " ";

  // commands are applied last so a manual load wins over a same-cycle UPDATE
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      t_lat <= '0;
      h_lat <= '0;
      max_temp <= DATA_W'(MAX_TEMP_RST);
      min_temp <= DATA_W'(MIN_TEMP_RST);
      max_hum <= DATA_W'(MAX_HUM_RST);
      min_hum <= DATA_W'(MIN_HUM_RST);
      manual <= 1'b0;
      fan_on <= 1'b0;
      hum_on <= 1'b0;
      alarm <= 1'b0;
      sens_fault <= 1'b0;
      cmd_ack <= 1'b0;
      cmd_err <= 1'b0;
      lcd_en <= 1'b0;
      lcd_row1 <= LCD_TITLE;
      lcd_row2 <= LCD_WELCOME;
    end else begin
      cmd_ack <= cmd_valid && cmd_ok;
      cmd_err <= cmd_valid && !cmd_ok;
      lcd_en <= state == S_SHOW;
      if (state == S_WAIT && sens_ready) begin
        t_lat <= temperature;
        h_lat <= humidity;
        sens_fault <= 1'b0;
      end else if (state == S_WAIT && timeout) begin
        sens_fault <= 1'b1;
        if (!manual) begin
          fan_on <= 1'b0;
          hum_on <= 1'b0;
          alarm <= 1'b1;
        end
      end
      if (state == S_UPDATE) begin
        alarm <= t_lat < min_temp || h_lat > max_hum;
        if (!manual) begin
          fan_on <= fan_nx;
          hum_on <= hum_nx;
        end
      end
      if (state == S_SHOW) begin
        lcd_row1 <= {"Temp: ", t_asc, " C   ", mode_ch, "  "};
        lcd_row2 <= sens_fault ? LCD_FAULT : {"Humi: ", h_asc, "%   ", fan_ch, hum_ch, alm_ch, " "};
      end
      if (cmd_valid && cmd_ok) begin
        if (cmd_byte == CMD_MAX_T) max_temp <= cmd_num;
        if (cmd_byte == CMD_MIN_T) min_temp <= cmd_num;
        if (cmd_byte == CMD_MAX_H) max_hum <= cmd_num;
        if (cmd_byte == CMD_MIN_H) min_hum <= cmd_num;
        if (cmd_byte == CMD_LOAD) begin
          manual <= 1'b1;
          fan_on <= cmd_val0 != ASCII_0;
          hum_on <= cmd_val1 != ASCII_0;
        end
        if (cmd_byte == CMD_MODE) manual <= cmd_val0 != ASCII_0;
      end
    end
endmodule

// File: tb/tb_climate_ctrl.sv
// tb_climate_ctrl: randomized scoreboard bench for climate_ctrl against a behavioural model
module tb_climate_ctrl;
  localparam int HYST = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [7:0] temperature = '0, humidity = '0, cmd_byte = '0, cmd_val0 = '0, cmd_val1 = '0;
  logic sens_ready = 1'b0, cmd_valid = 1'b0;
  logic sens_req, cmd_ack, cmd_err, fan_on, hum_on, alarm, sens_fault, lcd_en;
  logic [127:0] lcd_row1, lcd_row2;

  always #5 clk = ~clk;

  climate_ctrl #(.DATA_W(8), .REFRESH_CYCLES(20), .TIMEOUT_CYCLES(8), .HYST(HYST)) dut (
    .clk(clk), .rst_n(rst_n), .temperature(temperature), .humidity(humidity),
    .sens_req(sens_req), .sens_ready(sens_ready), .cmd_valid(cmd_valid),
    .cmd_byte(cmd_byte), .cmd_val0(cmd_val0), .cmd_val1(cmd_val1),
    .cmd_ack(cmd_ack), .cmd_err(cmd_err), .fan_on(fan_on), .hum_on(hum_on),
    .alarm(alarm), .sens_fault(sens_fault), .lcd_en(lcd_en),
    .lcd_row1(lcd_row1), .lcd_row2(lcd_row2)
  );

  typedef struct {logic [127:0] r1, r2; logic fan, hum, alarm, fault; int cyc;} lcd_exp_t;
  typedef struct {logic ack, fan, hum; int cyc;} cmd_exp_t;
  lcd_exp_t lcd_q[$];
  cmd_exp_t cmd_q[$];
  int checks = 0, errors = 0, cyc = 0, next_req = 21;
  int m_max_t, m_min_t, m_max_h, m_min_h, m_t, m_h;
  logic m_manual, m_fan, m_hum, m_alarm, m_fault;

  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0;
    else cyc <= cyc + 1;

  task automatic chk_b(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %b required %b (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_r(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual \"%s\" required \"%s\" (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_max_t = 18; m_min_t = 0; m_max_h = 35; m_min_h = 10;
    m_t = 0; m_h = 0;
    m_manual = 0; m_fan = 0; m_hum = 0; m_alarm = 0; m_fault = 0;
  endtask

  function automatic logic [15:0] dig2(input int v);
    int s;
    s = v > 99 ? 99 : v;
    return {8'(48 + s / 10), 8'(48 + s % 10)};
  endfunction

  function automatic lcd_exp_t expect_lcd(input int c);
    lcd_exp_t e;
    logic [7:0] mc, fc, hc, ac;
    mc = m_manual ? "M" : "A";
    fc = m_fan ? "F" : "-";
    hc = m_hum ? "H" : "-";
    ac = m_alarm ? "!" : " ";
    e.r1 = {"Temp: ", dig2(m_t), " C   ", mc, "  "};
    e.r2 = m_fault ? "Sensor fault    " : {"Humi: ", dig2(m_h), "%   ", fc, hc, ac, " "};
    e.fan = m_fan; e.hum = m_hum; e.alarm = m_alarm; e.fault = m_fault; e.cyc = c;
    return e;
  endfunction

  task automatic model_sample(input int t, input int h);
    int off_t, on_h;
    off_t = m_max_t - HYST < 0 ? 0 : m_max_t - HYST;
    on_h = m_min_h + HYST > 255 ? 255 : m_min_h + HYST;
    m_t = t; m_h = h; m_fault = 0;
    if (!m_manual) begin
      if (t > m_max_t) m_fan = 1; else if (t <= off_t) m_fan = 0;
      if (h < m_min_h) m_hum = 1; else if (h >= on_h) m_hum = 0;
    end
    m_alarm = t < m_min_t || h > m_max_h;
  endtask

  task automatic model_cmd(input logic [7:0] b, v0, v1, output logic ok);
    logic dig;
    int n;
    dig = v0 >= "0" && v0 <= "9" && v1 >= "0" && v1 <= "9";
    n = (int'(v0) - 48) * 10 + (int'(v1) - 48);
    ok = 0;
    if (b == "A" && dig && n >= m_min_t) begin ok = 1; m_max_t = n; end
    if (b == "B" && dig && n <= m_max_t) begin ok = 1; m_min_t = n; end
    if (b == "C" && dig && n >= m_min_h) begin ok = 1; m_max_h = n; end
    if (b == "D" && dig && n <= m_max_h) begin ok = 1; m_min_h = n; end
    if (b == "L" && dig) begin ok = 1; m_manual = 1; m_fan = v0 != "0"; m_hum = v1 != "0"; end
    if (b == "M" && (v0 == "0" || v0 == "1")) begin ok = 1; m_manual = v0 == "1"; end
  endtask

  task automatic do_cmd(input logic [7:0] b, v0, v1);
    cmd_exp_t e;
    @(negedge clk);
    cmd_valid = 1; cmd_byte = b; cmd_val0 = v0; cmd_val1 = v1;
    model_cmd(b, v0, v1, e.ack);
    e.fan = m_fan; e.hum = m_hum; e.cyc = cyc + 1;
    cmd_q.push_back(e);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic rand_cmd();
    logic [7:0] ops [7] = '{"A", "B", "C", "D", "L", "M", "Z"};
    logic [7:0] b, v0, v1;
    b = ops[$urandom_range(0, 6)];
    v0 = $urandom_range(0, 7) != 0 ? 8'(48 + $urandom_range(0, b == "M" ? 1 : 9)) : "X";
    v1 = $urandom_range(0, 7) != 0 ? 8'(48 + $urandom_range(0, 9)) : ":";
    do_cmd(b, v0, v1);
  endtask

  task automatic wait_req(output int r);
    int n;
    n = 0;
    while (!sens_req && n < 80) begin
      @(negedge clk);
      n++;
    end
    r = cyc;
    chk_b("sens_req_seen", sens_req, 1'b1);
    chk_i("sens_req_cycle", r, next_req);
    if (!sens_req) $fatal(1, "sens_req never asserted");
  endtask

  // delay = cycles after sens_req before sens_ready; drop = let the request time out
  task automatic do_sample(input int t, input int h, input int delay, input bit drop);
    int r, d;
    wait_req(r);
    if (!drop) begin
      repeat (delay) @(negedge clk);
      sens_ready = 1; temperature = 8'(t); humidity = 8'(h);
      d = cyc;
      model_sample(t, h);
      lcd_q.push_back(expect_lcd(d + 3));
      @(negedge clk);
      sens_ready = 0; temperature = 8'($urandom); humidity = 8'($urandom);
      @(negedge clk);
      chk_b("ctl_fan", fan_on, m_fan);
      chk_b("ctl_hum", hum_on, m_hum);
      chk_b("ctl_alarm", alarm, m_alarm);
      chk_b("req_drop", sens_req, 1'b0);
      @(negedge clk);
      next_req = d + 24;
    end else begin
      m_fault = 1;
      if (!m_manual) begin m_fan = 0; m_hum = 0; m_alarm = 1; end
      lcd_q.push_back(expect_lcd(r + 9));
      while (cyc < r + 7) @(negedge clk);
      chk_b("fault_early", sens_fault, 1'b0);
      @(negedge clk);
      chk_b("fault_set", sens_fault, 1'b1);
      chk_b("fault_fan", fan_on, m_fan);
      chk_b("fault_alarm", alarm, m_alarm);
      chk_b("fault_req_drop", sens_req, 1'b0);
      @(negedge clk);
      next_req = r + 30;
    end
  endtask

  always @(negedge clk) begin : monitor
    cmd_exp_t ce;
    lcd_exp_t le;
    if (rst_n) begin
      if (cmd_ack || cmd_err) begin
        if (cmd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cmd_spurious: ack=%b err=%b with nothing pending (cycle %0d)", cmd_ack, cmd_err, cyc);
        end else begin
          ce = cmd_q.pop_front();
          chk_i("cmd_cycle", cyc, ce.cyc);
          chk_b("cmd_ack", cmd_ack, ce.ack);
          chk_b("cmd_err", cmd_err, !ce.ack);
          chk_b("cmd_fan", fan_on, ce.fan);
          chk_b("cmd_hum", hum_on, ce.hum);
        end
      end else if (cmd_q.size() != 0 && cmd_q[0].cyc <= cyc) begin
        ce = cmd_q.pop_front();
        checks++; errors++;
        $display("FAIL cmd_missing: no ack/err at cycle %0d, required ack=%b", cyc, ce.ack);
      end
      if (lcd_en) begin
        if (lcd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL lcd_spurious: lcd_en with nothing pending (cycle %0d)", cyc);
        end else begin
          le = lcd_q.pop_front();
          chk_i("lcd_cycle", cyc, le.cyc);
          chk_r("lcd_row1", lcd_row1, le.r1);
          chk_r("lcd_row2", lcd_row2, le.r2);
          chk_b("lcd_fan", fan_on, le.fan);
          chk_b("lcd_hum", hum_on, le.hum);
          chk_b("lcd_alarm", alarm, le.alarm);
          chk_b("lcd_fault", sens_fault, le.fault);
        end
      end else if (lcd_q.size() != 0 && lcd_q[0].cyc <= cyc) begin
        le = lcd_q.pop_front();
        checks++; errors++;
        $display("FAIL lcd_missing: no lcd_en at cycle %0d", cyc);
      end
    end
  end

  task automatic check_reset_state();
    chk_r("rst_row1", lcd_row1, "  Cold Storage  ");
    chk_r("rst_row2", lcd_row2, "     Welcome    ");
    chk_b("rst_fan", fan_on, 1'b0);
    chk_b("rst_hum", hum_on, 1'b0);
    chk_b("rst_alarm", alarm, 1'b0);
    chk_b("rst_fault", sens_fault, 1'b0);
    chk_b("rst_req", sens_req, 1'b0);
    chk_b("rst_lcd_en", lcd_en, 1'b0);
    chk_b("rst_ack", cmd_ack | cmd_err, 1'b0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1;
    check_reset_state();
    do_sample(20, 30, 2, 0);
    chk_r("row1_T20", lcd_row1, "Temp: 20 C   A  ");
    chk_b("fan_T20", fan_on, 1'b1);
    do_sample(17, 30, 0, 0);
    do_sample(16, 30, 3, 0);
    do_sample(16, 9, 1, 0);
    do_sample(16, 11, 5, 0);
    do_sample(16, 12, 7, 0);
    do_cmd("A", "2", "5");
    do_cmd("B", "3", "0");
    do_cmd("A", "X", "5");
    do_cmd("Z", "0", "0");
    do_sample(26, 20, 0, 0);
    do_sample(24, 20, 4, 0);
    do_cmd("L", "1", "0");
    do_sample(0, 20, 0, 0);
    chk_r("row1_manual", lcd_row1, "Temp: 00 C   M  ");
    chk_b("fan_manual", fan_on, 1'b1);
    do_cmd("M", "0", "0");
    do_sample(10, 20, 2, 0);
    chk_b("fan_auto_again", fan_on, 1'b0);
    do_sample(0, 0, 0, 1);
    chk_r("row2_fault", lcd_row2, "Sensor fault    ");
    do_sample(10, 150, 2, 0);
    chk_b("fault_cleared", sens_fault, 1'b0);
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) rand_cmd();
      if ($urandom_range(0, 9) == 0) do_sample(0, 0, 0, 1);
      else do_sample($urandom_range(0, 120), $urandom_range(0, 120), $urandom_range(0, 7), 0);
    end
    wait_req(r);
    #2 rst_n = 0;
    #1 chk_b("async_req_drop", sens_req, 1'b0);
    @(negedge clk);
    rst_n = 1;
    check_reset_state();
    model_reset();
    next_req = 21;
    do_sample(19, 40, 1, 0);
    repeat (3) @(negedge clk);
    chk_i("lcd_q_drained", lcd_q.size(), 0);
    chk_i("cmd_q_drained", cmd_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
